// File: rtl/hack_pkg.sv
// Shared definitions for the Hack datapath selector blocks.
// Provides the default word width, the select encodings and the word type.
// No ports; import with `import hack_pkg::*;`.
package hack_pkg;

  localparam int WORD_W = 16;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  typedef logic [WORD_W-1:0] word_t;

endpackage : hack_pkg

// File: rtl/mux2_way16.sv
// 2:1 WIDTH-bit word selector, purely combinational (zero latency).
// Ports: a_i/b_i data words, sel_i picks b_i when 1, out_o selected word.
// No clock, no reset, no flow control.
module mux2_way16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sel_i,
  output logic [WIDTH-1:0] out_o
);

  assign out_o = sel_i ? b_i : a_i;

endmodule : mux2_way16

// File: rtl/mux4_way16.sv
// 4:1 WIDTH-bit word selector with a combinational result and a registered copy.
// Ports: clk/reset (async active-high, registers only), a..d data, sel select,
//        out (0-cycle), out_q/sel_q (1-cycle copies, no enable, no handshake).
// Optional MUX4WAY16_PARITY_EN adds out_parity (comb) and out_parity_q (registered).
module mux4_way16
  import hack_pkg::*;
#(
  parameter int               WIDTH     = WORD_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q,
  output logic [1:0]       sel_q
`ifdef MUX4WAY16_PARITY_EN
  ,
  output logic             out_parity,
  output logic             out_parity_q
`endif
);

  logic [WIDTH-1:0] ab_w;
  logic [WIDTH-1:0] cd_w;

  // First level: choose within each pair by sel[0].
  mux2_way16 #(.WIDTH(WIDTH)) u_mux_ab (
    .a_i   (a),
    .b_i   (b),
    .sel_i (sel[0]),
    .out_o (ab_w)
  );

  mux2_way16 #(.WIDTH(WIDTH)) u_mux_cd (
    .a_i   (c),
    .b_i   (d),
    .sel_i (sel[0]),
    .out_o (cd_w)
  );

  // Second level: choose between the pairs by sel[1].
  mux2_way16 #(.WIDTH(WIDTH)) u_mux_out (
    .a_i   (ab_w),
    .b_i   (cd_w),
    .sel_i (sel[1]),
    .out_o (out)
  );

  logic [WIDTH-1:0] out_d;
  logic [1:0]       sel_d;

  assign out_d = out;
  assign sel_d = sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q <= RESET_VAL;
      sel_q <= SEL_A;
    end else begin
      out_q <= out_d;
      sel_q <= sel_d;
    end
  end

`ifdef MUX4WAY16_PARITY_EN
  logic parity_d;

  // Even parity: 1 when out carries an odd number of ones.
  assign out_parity = ^out;
  assign parity_d   = out_parity;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_parity_q <= 1'b0;
    end else begin
      out_parity_q <= parity_d;
    end
  end
`endif

endmodule : mux4_way16

// File: tb/tb_mux4_way16.sv
// Self-checking bench for mux4_way16: directed and random stimulus compared
// against an array-indexing reference model; clock pulsed by hand.
// Optional parity checks compile only with MUX4WAY16_PARITY_EN.
module tb_mux4_way16;
  import hack_pkg::*;

  logic        clk;
  logic        reset;
  logic [15:0] a, b, c, d;
  logic [1:0]  sel;
  logic [15:0] out;
  logic [15:0] out_q;
  logic [1:0]  sel_q;
`ifdef MUX4WAY16_PARITY_EN
  logic        out_parity;
  logic        out_parity_q;
`endif

  int checks = 0;
  int errors = 0;

  mux4_way16 #(.WIDTH(16), .RESET_VAL(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .sel   (sel),
    .out   (out),
    .out_q (out_q),
    .sel_q (sel_q)
`ifdef MUX4WAY16_PARITY_EN
    ,
    .out_parity   (out_parity),
    .out_parity_q (out_parity_q)
`endif
  );

  // Reference model: the four inputs as an array indexed by the select value.
  function automatic logic [15:0] ref_sel(input logic [15:0] wa, input logic [15:0] wb,
                                          input logic [15:0] wc, input logic [15:0] wd,
                                          input logic [1:0] s);
    logic [15:0] words [4];
    words[0] = wa;
    words[1] = wb;
    words[2] = wc;
    words[3] = wd;
    return words[s];
  endfunction

  // Parity reference: count ones, odd count gives 1.
  function automatic logic ref_parity(input logic [15:0] w);
    int ones = 0;
    for (int i = 0; i < 16; i++) ones += int'(w[i]);
    return (ones % 2) == 1;
  endfunction

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One full clock period; returns with clk low, 5 units after the rising edge.
  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  task automatic set_words(input logic [15:0] wa, input logic [15:0] wb,
                           input logic [15:0] wc, input logic [15:0] wd);
    a = wa; b = wb; c = wc; d = wd;
  endtask

  logic [15:0] exp_w;
  logic [1:0]  exp_s;
  logic [15:0] one_hot;

  initial begin
    clk   = 1'b0;
    reset = 1'b1;
    set_words(16'h0, 16'h0, 16'h0, 16'h0);
    sel   = SEL_A;

    // Reset with clock idle: registered outputs take reset values at once.
    #1;
    check16("reset_out_q", out_q, 16'h0000);
    check16("reset_sel_q", {14'h0, sel_q}, 16'h0000);

    // Fixed-pattern sweep, combinational path valid while reset is high.
    set_words(16'h0000, 16'hFFFF, 16'hAAAA, 16'h5555);
    sel = 2'd0; #1 check16("sweep_sel0", out, 16'h0000);
    sel = 2'd1; #1 check16("sweep_sel1", out, 16'hFFFF);
    sel = 2'd2; #1 check16("sweep_sel2", out, 16'hAAAA);
    sel = 2'd3; #1 check16("sweep_sel3", out, 16'h5555);
    check16("reset_hold_out_q", out_q, 16'h0000);

    // Walking one through each input in turn, all other inputs zero.
    for (int inp = 0; inp < 4; inp++) begin
      for (int bitn = 0; bitn < 16; bitn++) begin
        one_hot = 16'h0001 << bitn;
        set_words(inp == 0 ? one_hot : 16'h0, inp == 1 ? one_hot : 16'h0,
                  inp == 2 ? one_hot : 16'h0, inp == 3 ? one_hot : 16'h0);
        sel = 2'(inp);
        #1 check16($sformatf("walk_in%0d_bit%0d", inp, bitn), out, one_hot);
      end
    end

    // Random words, every select value each iteration.
    for (int it = 0; it < 1000; it++) begin
      set_words(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      for (int s = 0; s < 4; s++) begin
        sel = 2'(s);
        #1 check16($sformatf("rand_it%0d_sel%0d", it, s), out, ref_sel(a, b, c, d, sel));
      end
    end

    // Release reset; first edge captures the current out and sel.
    reset = 1'b0;
    set_words(16'h0, 16'h0, 16'h1234, 16'h0);
    sel = SEL_C;
    #1 check16("post_release_hold", out_q, 16'h0000);
    tick();
    check16("first_edge_out_q", out_q, 16'h1234);
    check16("first_edge_sel_q", {14'h0, sel_q}, 16'h0002);

    // Random clocked stream: registers follow with one cycle of latency.
    for (int cyc = 0; cyc < 200; cyc++) begin
      set_words(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      sel   = 2'($urandom_range(0, 3));
      exp_w = ref_sel(a, b, c, d, sel);
      exp_s = sel;
      #1 check16($sformatf("pipe_c%0d_pre", cyc), out, exp_w);
      tick();
      // Change inputs after the edge; registered values must not move.
      set_words(~a, ~b, ~c, ~d);
      sel = ~sel;
      #1;
      check16($sformatf("pipe_c%0d_out_q", cyc), out_q, exp_w);
      check16($sformatf("pipe_c%0d_sel_q", cyc), {14'h0, sel_q}, {14'h0, exp_s});
    end

    // Mid-stream reset pulse between edges while out = 0xBEEF.
    set_words(16'h0, 16'hBEEF, 16'h0, 16'h0);
    sel = SEL_B;
    tick();
    check16("pre_pulse_out_q", out_q, 16'hBEEF);
    check16("pre_pulse_sel_q", {14'h0, sel_q}, 16'h0001);
    #1 reset = 1'b1;
    #1;
    check16("pulse_out_q", out_q, 16'h0000);
    check16("pulse_sel_q", {14'h0, sel_q}, 16'h0000);
    check16("pulse_out_comb", out, 16'hBEEF);
    #1 reset = 1'b0;
    #1 check16("after_pulse_hold", out_q, 16'h0000);
    tick();
    check16("after_pulse_edge", out_q, 16'hBEEF);

`ifdef MUX4WAY16_PARITY_EN
    set_words(16'h0007, 16'h0003, 16'h0, 16'h0);
    sel = SEL_A;
    #1 check1("parity_0007", out_parity, ref_parity(out));
    check1("parity_0007_const", out_parity, 1'b1);
    tick();
    check1("parity_q_0007", out_parity_q, 1'b1);
    sel = SEL_B;
    #1 check1("parity_0003", out_parity, 1'b0);
    check1("parity_q_hold", out_parity_q, 1'b1);
    tick();
    check1("parity_q_0003", out_parity_q, 1'b0);
    for (int it = 0; it < 50; it++) begin
      set_words(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      sel = 2'($urandom_range(0, 3));
      exp_w = ref_sel(a, b, c, d, sel);
      #1 check1($sformatf("parity_rand%0d", it), out_parity, ref_parity(exp_w));
      tick();
      check1($sformatf("parity_q_rand%0d", it), out_parity_q, ref_parity(exp_w));
    end
    sel = SEL_A;
    a   = 16'h0001;
    tick();
    #1 reset = 1'b1;
    #1 check1("parity_q_reset", out_parity_q, 1'b0);
    reset = 1'b0;
`endif

    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mux4_way16
